// File: rtl/encrypt_pipe_rot_scramble.sv
// Letter-shift cipher with rotating offset and bit scramble, fed into a 2-entry output FIFO.
// PERM packs one 8-bit source index per output bit (entry i at [8i+7:8i]); all-ones selects bit-reverse.
module encrypt_pipe_rot_scramble #(
   parameter int unsigned       W      = 8,
   parameter logic [W*8-1:0]    PERM   = '1,
   parameter int unsigned       NALPHA = 26
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  din,
   input  logic          mode,
   input  logic          shift_en,
   input  logic [4:0]    shift_amt,
   input  logic [2:0]    rot_freq,
   input  logic          cfg_load,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  dout
);

   localparam int unsigned OW = (NALPHA > 2) ? $clog2(NALPHA) : 1;

   logic [W-1:0]  mem [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    count;
   logic [2:0]    rot_cnt;
   logic [OW-1:0] rot_off;

   logic          accept;
   logic          retire;
   logic          advance;
   int unsigned   s_eff;
   logic [W-1:0]  enc_pre;
   logic [W-1:0]  enc_out;
   logic [W-1:0]  dec_pre;
   logic [W-1:0]  dec_out;
   logic [W-1:0]  proc;

   function automatic logic [7:0] shift_letter(input logic [7:0] c, input int unsigned s,
                                               input logic enc);
      int unsigned base;
      int unsigned idx;
      int unsigned s26;
      logic [7:0]  r;
      r   = c;
      s26 = s % 26;
      if (c >= 8'h41 && c <= 8'h5A)
         base = 32'h41;
      else if (c >= 8'h61 && c <= 8'h7A)
         base = 32'h61;
      else
         base = 0;
      if (base != 0) begin
         idx = 32'(c) - base;
         idx = enc ? (idx + s26) % 26 : (idx + 26 - s26) % 26;
         r   = 8'(base + idx);
      end
      return r;
   endfunction

   assign in_ready  = (count < 2'd2);
   assign out_valid = (count != 2'd0);
   assign dout      = mem[rd_ptr];
   assign accept    = in_valid & in_ready;
   assign retire    = out_valid & out_ready;
   assign advance   = accept & shift_en & (rot_freq != 3'd0) & ~cfg_load;

   assign s_eff = ((32'(shift_amt) % NALPHA) + 32'(rot_off)) % NALPHA;

   for (genvar g = 0; g < W; g++) begin : g_perm
      localparam int unsigned SRC = (PERM == '1) ? (W - 1 - g) : 32'(PERM[g*8 +: 8]);
      assign enc_out[g]   = enc_pre[SRC];
      assign dec_pre[SRC] = din[g];
   end

   // Letter class is judged on the unscrambled value in both directions.
   always_comb begin
      enc_pre = din;
      dec_out = dec_pre;
      if (shift_en) begin
         enc_pre[7:0] = shift_letter(din[7:0], s_eff, 1'b1);
         dec_out[7:0] = shift_letter(dec_pre[7:0], s_eff, 1'b0);
      end
      proc = mode ? enc_out : dec_out;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem     <= '{default: '0};
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= '0;
         rot_cnt <= '0;
         rot_off <= '0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= proc;
            wr_ptr      <= ~wr_ptr;
         end
         if (retire)
            rd_ptr <= ~rd_ptr;
         case ({accept, retire})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase

         // >= rather than == so a lowered rot_freq steps on the next advancing beat.
         if (cfg_load) begin
            rot_cnt <= '0;
            rot_off <= '0;
         end else if (advance) begin
            if (rot_cnt >= rot_freq - 3'd1) begin
               rot_cnt <= '0;
               rot_off <= (rot_off == OW'(NALPHA - 1)) ? '0 : rot_off + OW'(1);
            end else begin
               rot_cnt <= rot_cnt + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_encrypt_pipe_rot_scramble.sv
// Directed bench for encrypt_pipe_rot_scramble at W=8 with default bit-reverse scramble.
module tb_encrypt_pipe_rot_scramble;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] din;
   logic       mode;
   logic       shift_en;
   logic [4:0] shift_amt;
   logic [2:0] rot_freq;
   logic       cfg_load;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] dout;

   int errors = 0;
   int checks = 0;

   encrypt_pipe_rot_scramble #(.W(8), .NALPHA(26)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din       (din),
      .mode      (mode),
      .shift_en  (shift_en),
      .shift_amt (shift_amt),
      .rot_freq  (rot_freq),
      .cfg_load  (cfg_load),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [7:0] d);
      in_valid = 1'b1;
      din      = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic beat_check(input string tag, input logic [7:0] d, input logic [7:0] exp);
      beat(d);
      check({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
      check(tag, dout, exp);
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; din = '0; mode = 1'b1; shift_en = 1'b1;
      shift_amt = 5'd3; rot_freq = 3'd0; cfg_load = 1'b0; out_ready = 1'b1;
      #3;
      check("rst_out_valid", {7'd0, out_valid}, 8'd0);
      check("rst_dout", dout, 8'h00);
      @(posedge clk); #1;
      rst = 1'b1;
      idle();
      check("rst_in_ready", {7'd0, in_ready}, 8'd1);

      // Basic encrypt/decrypt, wrap, passthrough, modulo reduction.
      beat_check("enc_A_s3", 8'h41, 8'h22);
      mode = 1'b0;
      beat_check("dec_22_s3", 8'h22, 8'h41);
      mode = 1'b1; shift_amt = 5'd1;
      beat_check("enc_z_wrap", 8'h7A, 8'h86);
      beat_check("enc_Z_wrap", 8'h5A, 8'h82);
      mode = 1'b0;
      beat_check("dec_a_wrap", 8'h86, 8'h7A);
      mode = 1'b1; shift_amt = 5'd7;
      beat_check("enc_nonletter", 8'h35, 8'hAC);
      shift_amt = 5'd29;
      beat_check("enc_amt_mod", 8'h41, 8'h22);
      shift_en = 1'b0; shift_amt = 5'd3;
      beat_check("enc_shift_off", 8'h41, 8'h82);
      shift_en = 1'b1; shift_amt = 5'd0;
      check("hi_bits_none", dout, 8'h82);
      idle();
      check("drain_valid", {7'd0, out_valid}, 8'd0);

      // Rotation every two shifting beats: a,a,b,b,c.
      rot_freq = 3'd2;
      beat_check("rot1", 8'h61, 8'h86);
      beat_check("rot2", 8'h61, 8'h86);
      beat_check("rot3", 8'h61, 8'h46);
      beat_check("rot4", 8'h61, 8'h46);
      beat_check("rot5", 8'h61, 8'hC6);
      cfg_load = 1'b1;
      beat_check("rot_cfg_same", 8'h61, 8'hC6);
      cfg_load = 1'b0;
      beat_check("rot_after_clr1", 8'h61, 8'h86);
      beat_check("rot_after_clr2", 8'h61, 8'h86);
      beat_check("rot_after_clr3", 8'h61, 8'h46);
      cfg_load = 1'b1;
      idle();
      cfg_load = 1'b0;
      beat_check("rot_cfg_only", 8'h61, 8'h86);

      // Lowering rot_freq with rot_cnt already past the new limit.
      cfg_load = 1'b1; idle(); cfg_load = 1'b0;
      rot_freq = 3'd4;
      beat_check("freq4_1", 8'h61, 8'h86);
      beat_check("freq4_2", 8'h61, 8'h86);
      beat_check("freq4_3", 8'h61, 8'h86);
      rot_freq = 3'd2;
      beat_check("freq_chg_step", 8'h61, 8'h86);
      beat_check("freq_chg_after", 8'h61, 8'h46);
      rot_freq = 3'd0;
      cfg_load = 1'b1; idle(); cfg_load = 1'b0;

      // Backpressure: two entries accepted, third held off until space frees.
      shift_en = 1'b0; out_ready = 1'b0;
      in_valid = 1'b1; din = 8'h01;
      idle();
      check("bp_ready1", {7'd0, in_ready}, 8'd1);
      check("bp_dout1", dout, 8'h80);
      din = 8'h02;
      idle();
      check("bp_ready2", {7'd0, in_ready}, 8'd0);
      check("bp_hold2", dout, 8'h80);
      din = 8'h03;
      idle();
      check("bp_ready3", {7'd0, in_ready}, 8'd0);
      check("bp_hold3", dout, 8'h80);
      check("bp_valid3", {7'd0, out_valid}, 8'd1);
      out_ready = 1'b1;
      idle();
      check("bp_out2", dout, 8'h40);
      check("bp_ready4", {7'd0, in_ready}, 8'd1);
      idle();
      in_valid = 1'b0;
      check("bp_out3", dout, 8'hC0);
      idle();
      check("bp_empty", {7'd0, out_valid}, 8'd0);

      // Reset with two buffered beats and a nonzero rotation offset.
      shift_en = 1'b1; shift_amt = 5'd0; rot_freq = 3'd1; out_ready = 1'b0;
      beat(8'h61);
      beat(8'h61);
      check("pre_rst_full", {7'd0, in_ready}, 8'd0);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_valid", {7'd0, out_valid}, 8'd0);
      check("mid_rst_dout", dout, 8'h00);
      @(posedge clk); #1;
      rst = 1'b1;
      out_ready = 1'b1;
      idle();
      check("post_rst_no_ghost", {7'd0, out_valid}, 8'd0);
      beat_check("post_rst_rotoff0", 8'h61, 8'h86);
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
